// File: rtl/redirect_ctrl.sv
// -----------------------------------------------------------------------------
// redirect_ctrl
//
// Control-transfer redirect controller for the 5-stage pipeline. It watches the
// execute-stage branch/jump decision. On a taken transfer it kills the younger
// wrong-path instructions in IF/ID and ID/EX, and steers the PC mux to the
// resolved target. If fetch is busy, the target is parked in tgt_q and the
// redirect is held until fetch accepts it. Saturating statistics counters
// feed the performance report.
//
// Parameters
//   PC_W   PC / target width
//   CNT_W  statistics counter width
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous reset, active-low
//   ex_valid        EX stage holds a valid instruction
//   ex_is_cti       EX instruction is a branch or jump
//   brchcnd         EX control transfer is taken (1) / not taken (0)
//   ex_target       resolved target address
//   fetch_stall     fetch cannot accept a PC redirect this cycle
//   clr_cnt         synchronous clear of all statistics counters
//   redirect_valid  PC mux selects redirect_pc this cycle
//   redirect_pc     redirect address
//   flush_ifid      bubble the IF/ID register at the next edge
//   flush_idex      bubble the ID/EX register at the next edge
//   align_err       one-cycle pulse: taken target has bit 0 set
//   cnt_cti         resolved control transfers
//   cnt_taken       taken control transfers
//   cnt_stall       cycles spent waiting for fetch to accept a redirect
// -----------------------------------------------------------------------------
module redirect_ctrl #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_cti,
  input  logic             brchcnd,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             fetch_stall,
  input  logic             clr_cnt,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             align_err,
  output logic [CNT_W-1:0] cnt_cti,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_stall
);

  typedef enum logic {
    IDLE = 1'b0,  // no redirect outstanding
    PEND = 1'b1   // redirect parked in tgt_q, waiting for fetch
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] tgt_q;

  // Branch events are only honoured in IDLE; an EX instruction seen while a
  // redirect is pending is a protocol violation and is dropped entirely.
  logic cti_evt;
  logic tk;
  assign cti_evt = (state_q == IDLE) && ex_valid && ex_is_cti;
  assign tk      = cti_evt && brchcnd;

  // ---------------------------------------------------------------------------
  // State and parked target
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low reset in the sensitivity list, so reset takes effect at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (tk && fetch_stall) begin
        tgt_q <= ex_target;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default at the top of the block so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    redirect_valid = 1'b0;
    redirect_pc    = tgt_q;
    flush_ifid     = 1'b0;
    flush_idex     = 1'b0;
    align_err      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tk) begin
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          redirect_pc = ex_target;
          // A misaligned target is flagged but still followed unmodified.
          align_err   = ex_target[0];
          if (fetch_stall) begin
            state_d = PEND;
          end else begin
            redirect_valid = 1'b1;
          end
        end
      end

      PEND: begin
        // Keep killing whatever fetch delivers until the redirect lands;
        // ID/EX already holds post-flush content, so it is left alone.
        redirect_valid = 1'b1;
        flush_ifid     = 1'b1;
        if (!fetch_stall) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_cti   <= '0;
      cnt_taken <= '0;
      cnt_stall <= '0;
    end else if (clr_cnt) begin
      // Clear wins over any increment in the same cycle.
      cnt_cti   <= '0;
      cnt_taken <= '0;
      cnt_stall <= '0;
    end else begin
      if (cti_evt)           cnt_cti   <= sat_inc(cnt_cti);
      if (tk)                cnt_taken <= sat_inc(cnt_taken);
      if (state_q == PEND)   cnt_stall <= sat_inc(cnt_stall);
    end
  end

endmodule

// File: tb/tb_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_redirect_ctrl
//
// Scoreboard bench for redirect_ctrl. The driver applies one cycle of stimulus,
// asks a behavioural model what every output should read during that cycle,
// and queues the answer. A monitor on the falling edge pops and compares.
// Two instances share the stimulus: one with 16-bit counters and one with
// 4-bit counters, so saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_redirect_ctrl;

  localparam int PC_W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid, ex_is_cti, brchcnd, fetch_stall, clr_cnt;
  logic [PC_W-1:0] ex_target;

  logic            rv_a, fi_a, fd_a, ae_a;
  logic [PC_W-1:0] pc_a;
  logic [15:0]     cti_a, tk_a, st_a;
  logic            rv_b, fi_b, fd_b, ae_b;
  logic [PC_W-1:0] pc_b;
  logic [3:0]      cti_b, tk_b, st_b;

  always #5 clk = ~clk;

  redirect_ctrl #(.PC_W(PC_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_cti(ex_is_cti),
    .brchcnd(brchcnd), .ex_target(ex_target), .fetch_stall(fetch_stall),
    .clr_cnt(clr_cnt), .redirect_valid(rv_a), .redirect_pc(pc_a),
    .flush_ifid(fi_a), .flush_idex(fd_a), .align_err(ae_a),
    .cnt_cti(cti_a), .cnt_taken(tk_a), .cnt_stall(st_a)
  );

  redirect_ctrl #(.PC_W(PC_W), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_cti(ex_is_cti),
    .brchcnd(brchcnd), .ex_target(ex_target), .fetch_stall(fetch_stall),
    .clr_cnt(clr_cnt), .redirect_valid(rv_b), .redirect_pc(pc_b),
    .flush_ifid(fi_b), .flush_idex(fd_b), .align_err(ae_b),
    .cnt_cti(cti_b), .cnt_taken(tk_b), .cnt_stall(st_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic            rv;
    logic [PC_W-1:0] pc;
    logic            fi, fd, ae;
    int              n_cti, n_tk, n_st;     // 16-bit counters
    int              n_cti4, n_tk4, n_st4;  // 4-bit counters
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("redirect_valid", 32'(rv_a), 32'(e.rv));
      check("redirect_pc",    32'(pc_a), 32'(e.pc));
      check("flush_ifid",     32'(fi_a), 32'(e.fi));
      check("flush_idex",     32'(fd_a), 32'(e.fd));
      check("align_err",      32'(ae_a), 32'(e.ae));
      check("cnt_cti",        32'(cti_a), e.n_cti);
      check("cnt_taken",      32'(tk_a),  e.n_tk);
      check("cnt_stall",      32'(st_a),  e.n_st);
      check("w4_redirect_pc", 32'(pc_b),  32'(e.pc));
      check("w4_cnt_cti",     32'(cti_b), e.n_cti4);
      check("w4_cnt_taken",   32'(tk_b),  e.n_tk4);
      check("w4_cnt_stall",   32'(st_b),  e.n_st4);
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: "is a redirect still owed to fetch, and to where",
  // plus plain integer event tallies clipped at the counter maximum.
  // ---------------------------------------------------------------------------
  bit              owed;
  logic [PC_W-1:0] last_tgt;
  int              m_cti, m_tk, m_st, m_cti4, m_tk4, m_st4;

  function automatic int bump(input int v, input int cap);
    return (v < cap) ? v + 1 : cap;
  endfunction

  task automatic model_reset();
    owed = 0; last_tgt = '0;
    m_cti = 0; m_tk = 0; m_st = 0; m_cti4 = 0; m_tk4 = 0; m_st4 = 0;
  endtask

  // One clock cycle: drive, predict, queue, advance to just after the edge.
  task automatic cycle(input bit ev, input bit cti, input bit bc,
                       input logic [PC_W-1:0] tgt, input bit stall, input bit clr);
    exp_t e;
    bit   resolved, taken;
    ex_valid = ev; ex_is_cti = cti; brchcnd = bc;
    ex_target = tgt; fetch_stall = stall; clr_cnt = clr;

    resolved = !owed && ev && cti;
    taken    = resolved && bc;
    e.rv = owed || (taken && !stall);
    e.pc = taken ? tgt : last_tgt;
    e.fi = owed || taken;
    e.fd = taken;
    e.ae = taken && tgt[0];
    e.n_cti = m_cti;   e.n_tk = m_tk;   e.n_st = m_st;
    e.n_cti4 = m_cti4; e.n_tk4 = m_tk4; e.n_st4 = m_st4;
    exp_q.push_back(e);

    if (clr) begin
      m_cti = 0; m_tk = 0; m_st = 0; m_cti4 = 0; m_tk4 = 0; m_st4 = 0;
    end else begin
      if (resolved) begin m_cti = bump(m_cti, 65535); m_cti4 = bump(m_cti4, 15); end
      if (taken)    begin m_tk  = bump(m_tk, 65535);  m_tk4  = bump(m_tk4, 15);  end
      if (owed)     begin m_st  = bump(m_st, 65535);  m_st4  = bump(m_st4, 15);  end
    end
    if (owed) owed = stall;
    else if (taken && stall) begin owed = 1; last_tgt = tgt; end

    @(posedge clk); #1;
  endtask

  // Reset asserted mid-cycle: outputs must be zero straight away.
  task automatic reset_cycle();
    exp_t e;
    ex_valid = 0; ex_is_cti = 0; brchcnd = 0; ex_target = '0;
    fetch_stall = 0; clr_cnt = 0;
    rst = 1'b0;
    model_reset();
    e.rv = 0; e.pc = '0; e.fi = 0; e.fd = 0; e.ae = 0;
    e.n_cti = 0; e.n_tk = 0; e.n_st = 0; e.n_cti4 = 0; e.n_tk4 = 0; e.n_st4 = 0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b0;
    ex_valid = 0; ex_is_cti = 0; brchcnd = 0; ex_target = '0;
    fetch_stall = 0; clr_cnt = 0;
    model_reset();
    @(posedge clk); #1;
    reset_cycle();
    cycle(0, 0, 0, 16'h0000, 0, 0);

    // Unstalled taken, then a quiet cycle.
    cycle(1, 1, 1, 16'h0040, 0, 0);
    cycle(0, 0, 0, 16'h0000, 0, 0);

    // Stalled taken: stall on tk cycle and two more, accepted on the third.
    cycle(1, 1, 1, 16'h0100, 1, 0);
    cycle(0, 0, 0, 16'h0000, 1, 0);
    cycle(0, 0, 0, 16'h0000, 1, 0);
    cycle(0, 0, 0, 16'h0000, 0, 0);
    cycle(0, 0, 0, 16'h0000, 0, 0);

    // Not-taken CTI, then a misaligned taken one.
    cycle(1, 1, 0, 16'h0200, 0, 0);
    cycle(1, 1, 1, 16'h0007, 0, 0);
    cycle(0, 0, 0, 16'h0000, 0, 0);

    // Back-to-back: stalled taken, accepted, then taken right after.
    cycle(1, 1, 1, 16'h0300, 1, 0);
    cycle(0, 0, 0, 16'h0000, 0, 0);
    cycle(1, 1, 1, 16'h0310, 0, 0);

    // Protocol violation while pending: must be ignored.
    cycle(1, 1, 1, 16'h1234, 1, 0);
    cycle(1, 1, 1, 16'h5555, 1, 0);
    cycle(1, 1, 1, 16'h5557, 0, 0);
    cycle(0, 0, 0, 16'h0000, 0, 0);

    // Reset while a redirect to 0x1234 is pending.
    cycle(1, 1, 1, 16'h1234, 1, 0);
    cycle(0, 0, 0, 16'h0000, 1, 0);
    reset_cycle();
    cycle(0, 0, 0, 16'h0000, 0, 0);

    // Saturation: 17 taken CTIs pin the 4-bit counters at 15.
    for (int i = 0; i < 17; i++) cycle(1, 1, 1, 16'(16'h0400 + 2 * i), 0, 0);
    cycle(0, 0, 0, 16'h0000, 0, 0);
    // Stall counter saturation on the 4-bit copy.
    cycle(1, 1, 1, 16'h0500, 1, 0);
    for (int i = 0; i < 17; i++) cycle(0, 0, 0, 16'h0000, 1, 0);
    cycle(0, 0, 0, 16'h0000, 0, 0);
    // Clear with a same-cycle taken CTI.
    cycle(1, 1, 1, 16'h0600, 0, 1);
    cycle(0, 0, 0, 16'h0000, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) != 0),
            bit'($urandom_range(0, 1)), 16'($urandom),
            bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 39) == 0));
      if ($urandom_range(0, 199) == 0) reset_cycle();
    end
    cycle(0, 0, 0, 16'h0000, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Control-transfer redirect controller for the 5-stage pipeline. It consumes the execute-stage taken/not-taken decision (`brchcnd`) for branches and jumps, and kills the younger wrong-path instructions in IF/ID and ID/EX. It steers the PC mux to the target, holding the redirect until fetch can accept it. It also keeps saturating branch statistics counters for the performance report.

## Interface
- `PC_W`, 16: PC and target width.
- `CNT_W`, 16: statistics counter width.

- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: asynchronous reset, active-low (asserts immediately when 0; released synchronously by the surrounding design).
- `ex_valid` input 1: EX stage holds a valid instruction.
- `ex_is_cti` input 1: EX instruction is a branch or jump.
- `brchcnd` input 1: the EX control transfer is taken (1) or not taken (0). Only meaningful with `ex_valid & ex_is_cti`.
- `ex_target` input PC_W: resolved target address.
- `fetch_stall` input 1: fetch cannot accept a PC redirect this cycle (I-mem busy).
- `clr_cnt` input 1: synchronous clear of all counters.
- `redirect_valid` output 1: PC mux selects `redirect_pc` this cycle.
- `redirect_pc` output PC_W: redirect address.
- `flush_ifid` output 1: convert the IF/ID register contents to a bubble at the next edge.
- `flush_idex` output 1: convert the ID/EX register contents to a bubble at the next edge.
- `align_err` output 1: one-cycle pulse, taken target has bit 0 set.
- `cnt_cti` output CNT_W: resolved control transfers.
- `cnt_taken` output CNT_W: taken control transfers.
- `cnt_stall` output CNT_W: cycles spent in PEND.

## Operation
- **Taken event** `tk = ex_valid & ex_is_cti & brchcnd`, evaluated only in IDLE. In PEND it is ignored and not counted.
- **FSM states:** IDLE and PEND. Target register `tgt_q` is PC_W bits wide.
- **IDLE, `tk=1`:**
  - `flush_ifid=1`, `flush_idex=1`, `redirect_pc=ex_target` (combinational).
  - If `fetch_stall=0`: `redirect_valid=1` and the FSM stays in IDLE.
  - If `fetch_stall=1`: `redirect_valid=0`, `tgt_q<=ex_target`, and the FSM moves to PEND.
- **IDLE, `tk=0`:** all control outputs are 0 and `redirect_pc=tgt_q`.
- **PEND:**
  - `redirect_valid=1`, `redirect_pc=tgt_q`, `flush_ifid=1`, `flush_idex=0`.
  - The FSM stays in PEND while `fetch_stall=1`. It returns to IDLE at the first edge where `fetch_stall=0`, which is the cycle the redirect is accepted.
  - `ex_valid=1` in PEND is a protocol violation. It is ignored: no flush change, no counting.
- **`align_err`:** equals `tk & ex_target[0]` in IDLE only. The redirect still proceeds with the unmodified target.
- **Counters:** saturate at all-ones and never wrap.
  - `cnt_cti` increments on `ex_valid & ex_is_cti` in IDLE.
  - `cnt_taken` increments on `tk` in IDLE.
  - `cnt_stall` increments on every cycle in which the state is PEND.
  - `clr_cnt=1` zeroes all three counters at the edge and overrides any same-cycle increment.
- **Not-taken CTI:** only `cnt_cti` changes; no flush or redirect is issued.

## Timing
- **Reset (`rst=0`):** state=IDLE, `tgt_q=0`, all counters 0. All outputs read 0, including `redirect_pc=0`, provided `ex_valid=0`.
- **Reset mid-PEND:** the pending redirect is discarded and the FSM is in IDLE immediately.
- **Unstalled taken:** latency 0. Redirect and flushes are in the same cycle as `tk`.
- **Stalled taken:** `redirect_valid` rises the cycle after `tk` and stays high through the accepting cycle.
  - Total redirect-high cycles = number of stalled cycles after the `tk` cycle, plus 1.
- **`flush_ifid`:** high on the `tk` cycle and every PEND cycle, so wrong-path fetches delivered during the stall are killed.
- **Back-to-back:** a `tk` in the cycle immediately after returning to IDLE is handled normally.
- **Counter updates:** visible the cycle after the counted event.

## Test plan
- **Reset values:** assert `rst=0` mid-PEND with `tgt_q=0x1234` → outputs are 0 and the state is IDLE immediately. After release, `redirect_valid=0` and all counters are 0.
- **Unstalled taken:** `tk` with `ex_target=0x0040`, `fetch_stall=0` → same cycle `redirect_valid=1`, `redirect_pc=0x0040`, both flushes 1. Next cycle all are 0. `cnt_cti=1`, `cnt_taken=1`.
- **Stalled taken:** `tk` with `ex_target=0x0100`, `fetch_stall=1` for 3 cycles then 0 → cycle 0: flushes=1, `redirect_valid=0`. Cycles 1–3: `redirect_valid=1`, `redirect_pc=0x0100`, `flush_ifid=1`, `flush_idex=0`. Cycle 4: IDLE. `cnt_stall=3`.
- **Not-taken then taken:** a not-taken CTI, then a taken one at `0x0007` unstalled → `cnt_cti=2`, `cnt_taken=1`, `align_err` pulses once, `redirect_pc=0x0007`.
- **Protocol violation in PEND:** drive `ex_valid=ex_is_cti=brchcnd=1` during PEND → no counter change, `tgt_q` unchanged.
- **Saturation and clear:** preload via `CNT_W=4`, run 17 taken CTIs → counters hold 15. Assert `clr_cnt` together with a taken CTI → counters read 0 the next cycle.
